// File: rtl/argmax_feeder.sv
// argmax_feeder: collects a serial frame of up to eight signed scores, presents them
// in parallel to the argmax unit under a held enable, and returns the winning
// class index/value to the consumer over a valid/ready handshake.
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_data/in_last    serial score stream (class order 1..8)
//   in_ready                    feeder accepts a score this cycle (COLLECT only)
//   x_1..x_8, max_enable        parallel scores and enable to the argmax unit
//   max_outvalid/index/value    argmax result strobe and payload
//   res_valid/ready/index/value winning class returned to the consumer
//   frame_err                   one-cycle pulse on length mismatch or argmax timeout
module argmax_feeder #(
  parameter int unsigned featureWidth = 16,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [featureWidth-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [featureWidth-1:0] x_1,
  output logic [featureWidth-1:0] x_2,
  output logic [featureWidth-1:0] x_3,
  output logic [featureWidth-1:0] x_4,
  output logic [featureWidth-1:0] x_5,
  output logic [featureWidth-1:0] x_6,
  output logic [featureWidth-1:0] x_7,
  output logic [featureWidth-1:0] x_8,
  output logic                    max_enable,
  input  logic                    max_outvalid,
  input  logic [2:0]              max_index,
  input  logic [featureWidth-1:0] max_value,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2:0]              res_index,
  output logic [featureWidth-1:0] res_value,
  output logic                    frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [featureWidth-1:0] MIN = {1'b1, {(featureWidth-1){1'b0}}};
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT, RUN, DONE} state_t;

  state_t                  state;
  logic [2:0]              wcnt;
  logic [TW-1:0]           tcnt;
  logic [featureWidth-1:0] x_q [8];

  assign x_1 = x_q[0];
  assign x_2 = x_q[1];
  assign x_3 = x_q[2];
  assign x_4 = x_q[3];
  assign x_5 = x_q[4];
  assign x_6 = x_q[5];
  assign x_7 = x_q[6];
  assign x_8 = x_q[7];

  // Frame controller; x_q is reloaded with MIN whenever a new frame may begin so
  // slots past the last written word always read MIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      wcnt       <= 3'd0;
      tcnt       <= '0;
      in_ready   <= 1'b1;
      max_enable <= 1'b0;
      res_valid  <= 1'b0;
      res_index  <= 3'd0;
      res_value  <= MIN;
      frame_err  <= 1'b0;
      for (int i = 0; i < 8; i++) x_q[i] <= MIN;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid && in_ready) begin
            if (in_last || wcnt == 3'd7) begin
              // Frame ends: pad any unwritten slots, flag a short or unterminated frame.
              for (int i = 0; i < 8; i++) begin
                if (3'(i) > wcnt) x_q[i] <= MIN;
              end
              frame_err  <= (in_last != (wcnt == 3'd7));
              wcnt       <= 3'd0;
              tcnt       <= '0;
              in_ready   <= 1'b0;
              max_enable <= 1'b1;
              state      <= RUN;
            end else begin
              wcnt <= wcnt + 3'd1;
            end
            x_q[wcnt] <= in_data;
          end
        end
        RUN: begin
          if (max_outvalid) begin
            res_index  <= max_index;
            res_value  <= max_value;
            res_valid  <= 1'b1;
            max_enable <= 1'b0;
            tcnt       <= '0;
            state      <= DONE;
          end else if (tcnt == TLAST) begin
            // Argmax never answered: abandon the frame without a result.
            frame_err  <= 1'b1;
            max_enable <= 1'b0;
            tcnt       <= '0;
            in_ready   <= 1'b1;
            state      <= COLLECT;
            for (int i = 0; i < 8; i++) x_q[i] <= MIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            wcnt      <= 3'd0;
            tcnt      <= '0;
            in_ready  <= 1'b1;
            state     <= COLLECT;
            for (int i = 0; i < 8; i++) x_q[i] <= MIN;
          end
        end
        default: begin
          state    <= COLLECT;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
